// File: rtl/mul_seq_ctrl.sv
// Iterative shift-add multiply sequencer for the EX stage: freezes the front end
// and bubbles EX/MEM while the low DATA_W bits of a*b are accumulated chunk by chunk.
module mul_seq_ctrl #(
  parameter int DATA_W = 32,
  parameter int STEPS  = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              mul_valid_ID_EX,
  input  logic              kill,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic              pc_write,
  output logic              IF_ID_write,
  output logic              ID_EX_write,
  output logic              EX_MEM_bubble,
  output logic [DATA_W-1:0] mul_result,
  output logic              mul_result_valid,
  output logic              busy
);

  localparam int CHUNK = DATA_W / STEPS;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int PP_W  = DATA_W + CHUNK;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  a_q, b_q, acc;
  logic [CNT_W-1:0]   cnt;

  logic               start;
  logic               stall;
  logic               last_step;
  logic [31:0]        shift_amt;
  logic [CHUNK-1:0]   b_chunk;
  logic [PP_W-1:0]    partial;
  logic [PP_W-1:0]    partial_sh;
  logic [DATA_W-1:0]  acc_next;

  // One CHUNK-wide slice of b per step, weighted by its bit position.
  always_comb begin
    shift_amt  = 32'(cnt) * 32'(CHUNK);
    b_chunk    = b_q[shift_amt +: CHUNK];
    partial    = {{CHUNK{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_chunk};
    partial_sh = partial << shift_amt;
    acc_next   = acc + partial_sh[DATA_W-1:0];
  end

  always_comb begin
    start     = (state_q == IDLE) && mul_valid_ID_EX && !kill;
    stall     = start || (state_q == BUSY);
    last_step = (cnt == CNT_W'(STEPS - 1));
    state_d   = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // kill freezes the datapath so acc keeps whatever it had reached.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (start) begin
      a_q <= operand_a;
      b_q <= operand_b;
      acc <= '0;
      cnt <= '0;
    end else if ((state_q == BUSY) && !kill) begin
      acc <= acc_next;
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign pc_write         = !stall;
  assign IF_ID_write      = !stall;
  assign ID_EX_write      = !stall;
  assign EX_MEM_bubble    = stall;
  assign mul_result       = acc;
  assign mul_result_valid = (state_q == DONE);
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: stimulus pushes expected results with their
// due cycle, a monitor pops and compares whenever mul_result_valid is seen.
module tb_mul_seq_ctrl;

  localparam int DATA_W = 32;
  localparam int STEPS  = 4;

  logic              clk;
  logic              arst_n;
  logic              mul_valid_ID_EX;
  logic              kill;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic              pc_write;
  logic              IF_ID_write;
  logic              ID_EX_write;
  logic              EX_MEM_bubble;
  logic [DATA_W-1:0] mul_result;
  logic              mul_result_valid;
  logic              busy;

  typedef struct {
    logic [DATA_W-1:0] res;
    int                cyc;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   cyc;
  int   bubbles;

  mul_seq_ctrl #(.DATA_W(DATA_W), .STEPS(STEPS)) dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .mul_valid_ID_EX  (mul_valid_ID_EX),
    .kill             (kill),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .pc_write         (pc_write),
    .IF_ID_write      (IF_ID_write),
    .ID_EX_write      (ID_EX_write),
    .EX_MEM_bubble    (EX_MEM_bubble),
    .mul_result       (mul_result),
    .mul_result_valid (mul_result_valid),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input logic [DATA_W-1:0] actual,
                              input logic [DATA_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every presented result must match the oldest expectation, on time.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (EX_MEM_bubble) bubbles++;
      if (mul_result_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result: got 0x%08h with empty scoreboard (cycle %0d)",
                   mul_result, cyc);
        end else begin
          e = sb.pop_front();
          check_output("result_value", mul_result, e.res);
          check_output("result_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // Drives one MUL held in ID/EX until DONE, scrambling operands while BUSY.
  task automatic apply_stimulus(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                input logic [DATA_W-1:0] exp_res, input bit last);
    exp_t e;
    @(posedge clk); #2;
    mul_valid_ID_EX = 1'b1;
    operand_a       = a;
    operand_b       = b;
    e.res = exp_res;
    e.cyc = cyc + STEPS + 1;
    sb.push_back(e);
    @(negedge clk);
    check_output("stall_T_pc_write", 32'(pc_write), 32'd0);
    check_output("stall_T_bubble", 32'(EX_MEM_bubble), 32'd1);
    check_output("stall_T_busy", 32'(busy), 32'd0);
    for (int i = 1; i <= STEPS; i++) begin
      @(posedge clk); #2;
      operand_a = a ^ 32'hA5A5_5A5A;
      operand_b = ~b;
      @(negedge clk);
      check_output("busy_busy", 32'(busy), 32'd1);
      check_output("busy_id_ex_write", 32'(ID_EX_write), 32'd0);
    end
    @(posedge clk); #2;
    @(negedge clk);
    check_output("done_pc_write", 32'(pc_write), 32'd1);
    check_output("done_if_id_write", 32'(IF_ID_write), 32'd1);
    check_output("done_bubble", 32'(EX_MEM_bubble), 32'd0);
    if (last) begin
      @(posedge clk); #2;
      mul_valid_ID_EX = 1'b0;
      @(negedge clk);
      check_output("idle_after_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks          = 0;
    errors          = 0;
    cyc             = 0;
    bubbles         = 0;
    arst_n          = 1'b0;
    mul_valid_ID_EX = 1'b0;
    kill            = 1'b0;
    operand_a       = '0;
    operand_b       = '0;

    #3;
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_result", mul_result, 32'h0);
    check_output("reset_valid", 32'(mul_result_valid), 32'd0);
    check_output("reset_pc_write", 32'(pc_write), 32'd1);
    check_output("reset_bubble", 32'(EX_MEM_bubble), 32'd0);
    mul_valid_ID_EX = 1'b1;
    #1;
    check_output("reset_mulv_pc_write", 32'(pc_write), 32'd0);
    check_output("reset_mulv_bubble", 32'(EX_MEM_bubble), 32'd1);
    mul_valid_ID_EX = 1'b0;
    @(posedge clk); #2;
    arst_n = 1'b1;

    apply_stimulus(32'd3, 32'd5, 32'h0000_000F, 1'b1);
    apply_stimulus(32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b1);
    apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    apply_stimulus(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);

    // Back-to-back: second MUL enters ID/EX right at the end of DONE.
    @(posedge clk); #2;
    bubbles = 0;
    apply_stimulus(32'd2, 32'd7, 32'h0000_000E, 1'b0);
    apply_stimulus(32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 1'b1);
    check_output("b2b_bubbles", 32'(bubbles), 32'd10);

    // kill while BUSY: no result may ever be presented for this MUL.
    @(posedge clk); #2;
    mul_valid_ID_EX = 1'b1;
    operand_a       = 32'd9;
    operand_b       = 32'd9;
    @(posedge clk); #2;
    mul_valid_ID_EX = 1'b0;
    @(posedge clk); #2;
    kill = 1'b1;
    @(negedge clk);
    check_output("kill_cycle_pc_write", 32'(pc_write), 32'd0);
    @(posedge clk); #2;
    kill = 1'b0;
    @(negedge clk);
    check_output("kill_idle_busy", 32'(busy), 32'd0);
    check_output("kill_pc_write", 32'(pc_write), 32'd1);
    repeat (6) @(negedge clk);

    // Asynchronous reset mid-BUSY, then a fresh MUL.
    @(posedge clk); #2;
    mul_valid_ID_EX = 1'b1;
    operand_a       = 32'd11;
    operand_b       = 32'd13;
    @(posedge clk); #2;
    mul_valid_ID_EX = 1'b0;
    @(posedge clk); #2;
    arst_n = 1'b0;
    #1;
    check_output("arst_busy", 32'(busy), 32'd0);
    check_output("arst_result", mul_result, 32'h0);
    check_output("arst_pc_write", 32'(pc_write), 32'd1);
    check_output("arst_id_ex_write", 32'(ID_EX_write), 32'd1);
    check_output("arst_bubble", 32'(EX_MEM_bubble), 32'd0);
    @(posedge clk); #2;
    arst_n = 1'b1;
    apply_stimulus(32'd6, 32'd7, 32'h0000_002A, 1'b1);

    repeat (3) @(negedge clk);
    check_output("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequencer for the multi-cycle integer multiply in the EX stage of the 5-stage RISC-V pipeline. It captures a MUL instruction's operands from ID/EX and computes the low DATA_W bits of the product over STEPS iterations using an iterative shift-add over operand-B chunks. While it computes, it stalls the front of the pipeline and bubbles EX/MEM. It sits beside the ALU; its stall outputs are ANDed with the load-use/jump hazard enables before driving the PC and pipeline registers.

## Interface
Parameters:
- DATA_W, 32, operand and result width
- STEPS, 4, iterations per multiply; DATA_W % STEPS must be 0; CHUNK = DATA_W/STEPS

Ports:
- clk  in  1  clock, rising edge
- arst_n  in  1  asynchronous active-low reset
- mul_valid_ID_EX  in  1  instruction currently in EX is MUL
- kill  in  1  synchronous abort of any multiply in progress
- operand_a  in  DATA_W  rs1 value (post-forwarding)
- operand_b  in  DATA_W  rs2 value (post-forwarding)
- pc_write  out  1  PC enable
- IF_ID_write  out  1  IF/ID enable
- ID_EX_write  out  1  ID/EX enable
- EX_MEM_bubble  out  1  EX/MEM must load a NOP
- mul_result  out  DATA_W  low DATA_W bits of a*b
- mul_result_valid  out  1  mul_result valid; the EX/MEM register captures it this cycle
- busy  out  1  FSM not IDLE

## Operation
- States: IDLE, BUSY, DONE. Step counter cnt has width clog2(STEPS).
- Registers: a_q, b_q, acc, all DATA_W wide.
- stall = (IDLE & mul_valid_ID_EX & ~kill) | BUSY.
- pc_write = IF_ID_write = ID_EX_write = ~stall. EX_MEM_bubble = stall.
- IDLE:
  - If mul_valid_ID_EX & ~kill: load a_q = operand_a, b_q = operand_b, acc = 0, cnt = 0, then go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, each cycle:
  - acc <= acc + ((a_q * b_q[cnt*CHUNK +: CHUNK]) << (cnt*CHUNK)), truncated to DATA_W.
  - The partial product is DATA_W+CHUNK wide before the shift; keep only the low DATA_W bits of the sum.
  - cnt <= cnt+1. When cnt == STEPS-1, go to DONE.
- DONE:
  - mul_result_valid = 1 and mul_result = acc; stall = 0, so the pipeline advances for one edge.
  - Next state is unconditionally IDLE. A MUL that enters EX on that same edge starts from IDLE in the following cycle.
- mul_result holds the last acc at all times. It is meaningful only while mul_result_valid = 1.
- kill:
  - From any state, kill = 1 forces IDLE on the next edge and leaves acc unchanged.
  - Outputs in that cycle follow the stall equation, so stall = 0 except in BUSY. In BUSY the cycle is still stalled, and the pipeline resumes the cycle after.
- Signed and unsigned MUL give the same low DATA_W bits; no sign handling is required.

## Timing
- Reset (arst_n = 0, asynchronous):
  - State = IDLE; acc, a_q, b_q, cnt = 0.
  - mul_result = 0, mul_result_valid = 0, busy = 0.
  - pc_write = IF_ID_write = ID_EX_write = 1 unless mul_valid_ID_EX = 1; EX_MEM_bubble = 0 under the same condition.
- Deassertion of reset is synchronized externally; the block needs no extra state for it.
- MUL in EX at cycle T:
  - T: stall = 1 (combinational from IDLE).
  - T+1 .. T+STEPS: BUSY, stall = 1.
  - T+STEPS+1: DONE, stall = 0, mul_result_valid = 1.
  - Total latency STEPS+2 cycles in EX. Front end frozen for STEPS+1 cycles. EX/MEM receives STEPS+1 bubbles and then the result.
- Back-to-back MULs: the second MUL enters ID/EX at the end of DONE. It sees IDLE at cycle T+STEPS+2 and repeats the sequence; no cycle is lost beyond the sequence itself.
- operand_a and operand_b are sampled only on the IDLE→BUSY edge. Changes during BUSY are ignored.
- mul_valid_ID_EX is ignored in BUSY and DONE.
- Load-use hazards are resolved before a MUL reaches EX; this block never sees stale operands.

## Test plan
- Reset, then a MUL with a = 3, b = 5 at cycle T:
  - stall = 1 for T..T+4.
  - mul_result_valid = 1 with mul_result = 0x0000000F at T+5.
  - IDLE at T+6.
- a = 0x0000FFFF, b = 0x0000FFFF -> 0xFFFE0001.
- a = 0xFFFFFFFF, b = 0xFFFFFFFF -> 0x00000001.
- a = 0x00010000, b = 0x00010000 -> 0x00000000 (truncation).
- Back-to-back MULs (2*7 then 0x00010001*0x00010001):
  - Results 0x0000000E at T+5 and 0x00020001 at T+11.
  - Exactly 2 × 5 bubbles into EX/MEM.
- kill asserted at T+2:
  - IDLE at T+3; mul_result_valid never asserts.
  - pc_write = 1 from T+3.
- arst_n pulsed low mid-BUSY:
  - Immediately busy = 0, mul_result = 0, and all enables = 1 with mul_valid low.
  - A new MUL after release completes in 6 cycles.
